// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle for gate_unit_arbiter.
// master drives requests and consumes responses; slave is the arbiter side.
interface gate_unit_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_y;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise/reduction logic unit
// among NREQ requesters. One operation in flight: IDLE -> EXEC -> RESP.
// Optional statistics (op_count, last_grant) enabled by GATE_UNIT_ARBITER_STATS_EN.
module gate_unit_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  gate_unit_arbiter_if.slave    bus
`ifdef GATE_UNIT_ARBITER_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [$clog2(NREQ)-1:0] last_grant
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_c;
  logic [IDW-1:0]   idx_c;
  logic             found_c;
  logic             accept_c;
  logic [NREQ-1:0]  ready_c;
  logic [2:0]       sel_op_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDW-1:0]   g_q;
  logic [WIDTH-1:0] y_c;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_y_q;

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_c = IDW'((32'(ptr_q) + 32'(k)) % 32'(NREQ));
      if (!found_c && bus.req_valid[idx_c]) begin
        found_c = 1'b1;
        grant_c = idx_c;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c == IDW'(i)) begin
        sel_op_c = bus.req_op[3*i +: 3];
        sel_a_c  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b_c  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Next state and accept strobe; no grant while reset is asserted.
  always_comb begin
    state_d  = state_q;
    ready_c  = '0;
    accept_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          accept_c = 1'b1;
          state_d  = EXEC;
          for (int i = 0; i < NREQ; i++) begin
            ready_c[i] = (grant_c == IDW'(i));
          end
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ready_c  = '0;
      accept_c = 1'b0;
    end
  end

  // Shared logic unit operating on the latched operands.
  always_comb begin
    y_c = '0;
    unique case (op_q)
      3'd0:    y_c = ~a_q;
      3'd1:    y_c = a_q & b_q;
      3'd2:    y_c = a_q | b_q;
      3'd3:    y_c = a_q ^ b_q;
      3'd4:    y_c = ~(a_q & b_q);
      3'd5:    y_c = ~(a_q | b_q);
      3'd6:    y_c = WIDTH'(&a_q);
      3'd7:    y_c = WIDTH'(^a_q);
      default: y_c = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand latch, response registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      g_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      if (accept_c) begin
        op_q <= sel_op_c;
        a_q  <= sel_a_c;
        b_q  <= sel_b_c;
        g_q  <= grant_c;
      end
      if (state_q == EXEC) begin
        rsp_y_q     <= y_c;
        rsp_id_q    <= g_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        ptr_q       <= IDW'((32'(g_q) + 32'd1) % 32'(NREQ));
      end
    end
  end

`ifdef GATE_UNIT_ARBITER_STATS_EN
  // Completed-response counter (saturating) and most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count   <= '0;
      last_grant <= '0;
    end else begin
      if (accept_c) last_grant <= grant_c;
      if (state_q == RESP && bus.rsp_ready && op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
    end
  end
`endif

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_gate_unit_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDW   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gate_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

`ifdef GATE_UNIT_ARBITER_STATS_EN
  logic [15:0]    op_count;
  logic [IDW-1:0] last_grant;
`endif

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef GATE_UNIT_ARBITER_STATS_EN
    ,
    .op_count   (op_count),
    .last_grant (last_grant)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one job in flight, result visible two edges after accept.
  bit         m_busy = 1'b0;
  bit         m_rv   = 1'b0;
  int         m_ptr  = 0;
  int         m_g    = 0;
  int         m_id   = 0;
  int         m_cnt  = 0;
  int         m_last = 0;
  logic [2:0] m_op   = '0;
  logic [3:0] m_a    = '0;
  logic [3:0] m_b    = '0;
  logic [3:0] m_y    = '0;

  function automatic logic [3:0] gate_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return {3'b000, &a};
      default: return {3'b000, ^a};
    endcase
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    logic [3:0] r;
    r = '0;
    g = pick();
    if (!reset && !m_busy && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Model update on each rising edge.
  initial forever begin
    int g;
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_rv = 0; m_ptr = 0; m_g = 0; m_id = 0;
      m_y = '0; m_cnt = 0; m_last = 0;
    end else if (!m_busy) begin
      g = pick();
      if (g >= 0) begin
        m_g    = g;
        m_last = g;
        m_op   = 3'(bus.req_op >> (3 * g));
        m_a    = 4'(bus.req_a >> (4 * g));
        m_b    = 4'(bus.req_b >> (4 * g));
        m_busy = 1;
      end
    end else if (!m_rv) begin
      m_y  = gate_fn(m_op, m_a, m_b);
      m_id = m_g;
      m_rv = 1;
    end else if (bus.rsp_ready) begin
      m_rv   = 0;
      m_busy = 0;
      m_ptr  = (m_g + 1) % NREQ;
      if (m_cnt < 65535) m_cnt++;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      chk("rsp_y", 32'(bus.rsp_y), 32'(m_y));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
`ifdef GATE_UNIT_ARBITER_STATS_EN
      chk("op_count", 32'(op_count), 32'(m_cnt));
      chk("last_grant", 32'(last_grant), 32'(m_last));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.req_op[3*id +: 3] = op;
    bus.req_a[4*id +: 4]  = a;
    bus.req_b[4*id +: 4]  = b;
  endtask

  task automatic wait_ready(input int id, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready[id] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, " accept"}, 32'(bus.req_ready[id]), 32'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Single isolated transaction with operands scrambled after acceptance.
  task automatic do_one(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_y, input string name);
    int n;
    set_req(id, op, a, b);
    bus.req_valid[id] = 1'b1;
    wait_ready(id, name);
    tick();
    bus.req_valid[id] = 1'b0;
    set_req(id, ~op, ~a, ~b);
    wait_rsp(n);
    chk({name, " latency"}, 32'(n), 32'd1);
    chk({name, " y"}, 32'(bus.rsp_y), 32'(exp_y));
    chk({name, " id"}, 32'(bus.rsp_id), 32'(id));
    tick();
  endtask

  initial begin
    int n, acc_n, rsp_n, cyc;
    int acc_id[6];
    int acc_cyc[6];
    int rsp_id_log[6];
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset held two cycles with every requester valid.
    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_y", 32'(bus.rsp_y), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("first grant", 32'(bus.req_ready), 32'b0001);
    tick();
    drain();

    // Single AND on requester 0.
    do_one(0, 3'd1, 4'b1100, 4'b1010, 4'b1000, "and0");
    drain();

    // All requesters continuously valid from pointer 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 1), 4'(i + 3), 4'(9 - i));
    bus.req_valid = '1;
    acc_n = 0; rsp_n = 0; cyc = 0;
    while (rsp_n < 6 && cyc < 40) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i] && acc_n < 6) begin
          acc_id[acc_n]  = i;
          acc_cyc[acc_n] = cyc;
          acc_n++;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_id_log[rsp_n] = int'(bus.rsp_id);
        rsp_n++;
      end
      cyc++;
    end
    chk("rr accepts", 32'(acc_n), 32'd6);
    chk("rr responses", 32'(rsp_n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_n) chk("rr accept order", 32'(acc_id[i]), 32'(exp_order[i]));
      if (i < rsp_n) chk("rr rsp order", 32'(rsp_id_log[i]), 32'(exp_order[i]));
      if (i > 0 && i < acc_n) chk("rr spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    tick();
    drain();

    // Opcode coverage on requester 2.
    do_one(2, 3'd6, 4'hF,    4'h3,    4'b0001, "andr");
    do_one(2, 3'd7, 4'b1011, 4'h3,    4'b0001, "xorr");
    do_one(2, 3'd5, 4'h0,    4'h0,    4'hF,    "nor");
    do_one(2, 3'd0, 4'b0101, 4'h3,    4'b1010, "inv");
    do_one(2, 3'd4, 4'hF,    4'hF,    4'h0,    "nand");
    drain();

    // Response stall with requester 1 waiting.
    bus.rsp_ready = 1'b0;
    set_req(0, 3'd3, 4'h3, 4'h5);
    bus.req_valid[0] = 1'b1;
    wait_ready(0, "stall");
    tick();
    bus.req_valid[0] = 1'b0;
    set_req(1, 3'd1, 4'hF, 4'h6);
    bus.req_valid[1] = 1'b1;
    wait_rsp(n);
    chk("stall y", 32'(bus.rsp_y), 32'h6);
    chk("stall id", 32'(bus.rsp_id), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall hold valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall hold y", 32'(bus.rsp_y), 32'h6);
      chk("stall hold id", 32'(bus.rsp_id), 32'd0);
      chk("stall no ready", 32'(bus.req_ready), 32'd0);
      tick();
      if (i == 4) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    chk("stall handshake valid", 32'(bus.rsp_valid), 32'd1);
    chk("stall handshake ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("stall next grant", 32'(bus.req_ready), 32'b0010);
    tick();
    drain();

    // Reset during EXEC drops the job and returns the pointer to 0.
    set_req(3, 3'd2, 4'h1, 4'h2);
    set_req(0, 3'd3, 4'h5, 4'h6);
    bus.req_valid[3] = 1'b1;
    wait_ready(3, "midreset");
    tick();
    reset = 1'b1;
    bus.req_valid = 4'b1001;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midreset grant", 32'(bus.req_ready), 32'b0001);
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
